// File: rtl/rect_pixel_writer_if.sv
// rect_pixel_writer_if
// Write bus between the rectangle pixel writer and the SDRAM controller.
//   wr_req  : write request, held by the master until acknowledged
//   wr_addr : frame-buffer word address
//   wr_data : pixel data
//   wr_ack  : one-cycle accept returned by the SDRAM controller
interface rect_pixel_writer_if #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 16
);
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;

  modport master (output wr_req, output wr_addr, output wr_data, input wr_ack);
  modport slave  (input wr_req, input wr_addr, input wr_data, output wr_ack);
endinterface

// File: rtl/rect_pixel_writer.sv
// rect_pixel_writer
// Walks the rectangle outline generator point by point and turns each visible
// coordinate into one frame-buffer write. Off-screen coordinates are skipped.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   i_draw_req, i_color : start a rectangle with the given colour
//   i_abort             : level, stop the current rectangle
//   i_x_pos, i_y_pos    : current generator coordinate
//   i_all_done          : generator is on its last point
//   o_start_to_output   : kick pulse to the generator
//   o_renew             : advance pulse to the generator
//   o_busy              : high whenever not idle
//   o_frame_done        : pulse when a rectangle finishes or is aborted
//   o_error             : pulse when the generator is seen to stall
//   o_pix_count         : pixels written for this rectangle, saturating
//   wr_bus              : SDRAM write bus (master side)
//
// state  | meaning
// IDLE   | waiting for i_draw_req
// KICK   | pulse o_start_to_output
// SETTLE | let the generator's registered coordinate become valid
// CHECK  | sample all_done, detect stall, clip or launch a write
// WRITE  | hold the write request until acknowledged
// RENEW  | pulse o_renew
// WAIT1  | generator updates its coordinate
// WAIT2  | generator updates its done register
// DONE   | pulse o_frame_done
module rect_pixel_writer #(
  parameter int          H_RES     = 800,
  parameter int          V_RES     = 600,
  parameter int          ADDR_W    = 23,
  parameter int          DATA_W    = 16,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_draw_req,
  input  logic [DATA_W-1:0] i_color,
  input  logic              i_abort,
  input  logic [15:0]       i_x_pos,
  input  logic [15:0]       i_y_pos,
  input  logic              i_all_done,
  output logic              o_start_to_output,
  output logic              o_renew,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic              o_error,
  output logic [19:0]       o_pix_count,
  rect_pixel_writer_if.master wr_bus
);

  typedef enum logic [3:0] {
    IDLE, KICK, SETTLE, CHECK, WRITE, RENEW, WAIT1, WAIT2, DONE
  } state_t;

  state_t state, next_state;

  logic [DATA_W-1:0] color_q;
  logic              done_flag;
  logic [15:0]       last_x, last_y;
  logic              has_last;
  logic              wr_req_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [19:0]       pix_count_q;
  logic              error_q;

  logic              in_range;
  logic              stall;
  logic [ADDR_W-1:0] addr_calc;

  assign in_range = (i_x_pos < 16'(H_RES)) && (i_y_pos < 16'(V_RES));

  // "First point" means nothing has been written yet, so a clipped leading
  // point can never be mistaken for a repeat of the reset last-point value.
  assign stall = has_last && (i_x_pos == last_x) && (i_y_pos == last_y) && !i_all_done;

  // Full 32-bit product before truncation to the bus width.
  assign addr_calc = ADDR_W'(32'(BASE_ADDR) + 32'(i_y_pos) * 32'(H_RES) + 32'(i_x_pos));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:   if (i_draw_req) next_state = KICK;
      KICK:   next_state = i_abort ? DONE : SETTLE;
      SETTLE: next_state = i_abort ? DONE : CHECK;
      CHECK: begin
        if (i_abort || stall)   next_state = DONE;
        else if (in_range)      next_state = WRITE;
        else if (i_all_done)    next_state = DONE;
        else                    next_state = RENEW;
      end
      // Abort is deferred until the ack so a request is never withdrawn.
      WRITE:  if (wr_bus.wr_ack) next_state = (i_abort || done_flag) ? DONE : RENEW;
      RENEW:  next_state = i_abort ? DONE : WAIT1;
      WAIT1:  next_state = i_abort ? DONE : WAIT2;
      WAIT2:  next_state = i_abort ? DONE : CHECK;
      DONE:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    o_start_to_output = 1'b0;
    o_renew           = 1'b0;
    o_frame_done      = 1'b0;
    o_busy            = 1'b1;
    case (state)
      IDLE:  o_busy            = 1'b0;
      KICK:  o_start_to_output = 1'b1;
      RENEW: o_renew           = 1'b1;
      DONE:  o_frame_done      = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      color_q     <= '0;
      done_flag   <= 1'b0;
      last_x      <= '0;
      last_y      <= '0;
      has_last    <= 1'b0;
      wr_req_q    <= 1'b0;
      wr_addr_q   <= '0;
      pix_count_q <= '0;
      error_q     <= 1'b0;
    end else begin
      // WRITE is only ever occupied while a request is outstanding.
      wr_req_q <= (next_state == WRITE);
      error_q  <= (state == CHECK) && !i_abort && stall;
      case (state)
        IDLE: begin
          if (i_draw_req) begin
            color_q     <= i_color;
            pix_count_q <= '0;
            last_x      <= '0;
            last_y      <= '0;
            has_last    <= 1'b0;
            done_flag   <= 1'b0;
          end
        end
        CHECK: begin
          done_flag <= i_all_done;
          if (next_state == WRITE) wr_addr_q <= addr_calc;
        end
        WRITE: begin
          if (wr_bus.wr_ack) begin
            if (pix_count_q != 20'hFFFFF) pix_count_q <= pix_count_q + 20'd1;
            last_x   <= i_x_pos;
            last_y   <= i_y_pos;
            has_last <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign wr_bus.wr_req  = wr_req_q;
  assign wr_bus.wr_addr = wr_addr_q;
  assign wr_bus.wr_data = color_q;
  assign o_pix_count    = pix_count_q;
  assign o_error        = error_q;

endmodule

// File: tb/tb_rect_pixel_writer.sv
// tb_rect_pixel_writer
// Drives rect_pixel_writer with a point-list generator model and an SDRAM
// responder with programmable ack delay; expected results come from a
// point-list walk of the drawing rules.
module tb_rect_pixel_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_draw_req = 1'b0;
  logic [15:0] i_color = '0;
  logic        i_abort = 1'b0;
  logic [15:0] i_x_pos = '0;
  logic [15:0] i_y_pos = '0;
  logic        i_all_done = 1'b0;
  logic        o_start_to_output, o_renew, o_busy, o_frame_done, o_error;
  logic [19:0] o_pix_count;

  rect_pixel_writer_if #(.ADDR_W(23), .DATA_W(16)) wr_bus ();

  rect_pixel_writer dut (
    .clk               (clk),
    .rst               (rst),
    .i_draw_req        (i_draw_req),
    .i_color           (i_color),
    .i_abort           (i_abort),
    .i_x_pos           (i_x_pos),
    .i_y_pos           (i_y_pos),
    .i_all_done        (i_all_done),
    .o_start_to_output (o_start_to_output),
    .o_renew           (o_renew),
    .o_busy            (o_busy),
    .o_frame_done      (o_frame_done),
    .o_error           (o_error),
    .o_pix_count       (o_pix_count),
    .wr_bus            (wr_bus)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // generator point list
  int px[16];
  int py[16];
  bit pd[16];

  // reference results
  int exp_nw, exp_renew, exp_err;
  int exp_addr[16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Walk the point list: visible points are written, a repeat of the last
  // written point without done is a stall, done ends the rectangle, and an
  // abort ends it right after the chosen write.
  task automatic model(input int n, input int abort_at);
    int lx, ly;
    bit has;
    exp_nw = 0; exp_renew = 0; exp_err = 0; has = 0; lx = 0; ly = 0;
    for (int i = 0; i < n; i++) begin
      if (has && px[i] == lx && py[i] == ly && !pd[i]) begin
        exp_err = 1;
        break;
      end
      if (px[i] < 800 && py[i] < 600) begin
        exp_addr[exp_nw] = py[i] * 800 + px[i];
        exp_nw++;
        lx = px[i]; ly = py[i]; has = 1;
        if (abort_at == exp_nw - 1) break;
      end
      if (pd[i]) break;
      exp_renew++;
    end
  endtask

  task automatic run_rect(input string name, input int n, input int delay,
                          input int abort_at, input bit extra_req, input logic [15:0] colour);
    int cyc = 0, nw = 0, wlen = 0, renew_c = 0, start_c = 0, err_c = 0, fd_c = 0;
    int first_wr = -1, unstable = 0, drop_bad = 0, idx = 0, post = -1;
    logic [22:0] cur_addr = '0;
    logic [15:0] cur_data = '0;
    int oa[16];
    int od[16];
    int ol[16];
    model(n, abort_at);
    i_x_pos = 16'(px[0]); i_y_pos = 16'(py[0]); i_all_done = pd[0];
    @(negedge clk);
    i_color = colour;
    i_draw_req = 1'b1;
    while (post < 1 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      i_draw_req = 1'b0;
      if (extra_req && cyc == 6) begin
        i_draw_req = 1'b1;
        i_color = ~colour;
      end
      if (wr_bus.wr_ack) begin
        wr_bus.wr_ack = 1'b0;
        if (nw < 16) begin oa[nw] = int'(cur_addr); od[nw] = int'(cur_data); ol[nw] = wlen; end
        nw++;
        wlen = 0;
        if (wr_bus.wr_req) drop_bad++;
      end else if (wr_bus.wr_req) begin
        if (wlen == 0) begin
          cur_addr = wr_bus.wr_addr;
          cur_data = wr_bus.wr_data;
          if (first_wr < 0) first_wr = cyc;
        end else if (wr_bus.wr_addr !== cur_addr || wr_bus.wr_data !== cur_data) begin
          unstable++;
        end
        wlen++;
        if (abort_at == nw && wlen == 1) i_abort = 1'b1;
        if (wlen == delay + 1) wr_bus.wr_ack = 1'b1;
      end
      if (o_start_to_output) start_c++;
      if (o_renew) begin
        renew_c++;
        if (idx < n - 1) idx++;
        i_x_pos = 16'(px[idx]); i_y_pos = 16'(py[idx]); i_all_done = pd[idx];
      end
      if (o_error) err_c++;
      if (post >= 0) post++;
      if (o_frame_done) begin
        fd_c++;
        if (post < 0) post = 0;
        i_abort = 1'b0;
      end
    end
    check({name, " frame_done"}, fd_c, 1);
    check({name, " start_pulses"}, start_c, 1);
    check({name, " renews"}, renew_c, exp_renew);
    check({name, " error"}, err_c, exp_err);
    check({name, " writes"}, nw, exp_nw);
    for (int i = 0; i < exp_nw && i < nw; i++) begin
      check({name, " addr"}, oa[i], exp_addr[i]);
      check({name, " data"}, od[i], 32'(colour));
      check({name, " req_len"}, ol[i], delay + 1);
    end
    check({name, " addr_stable"}, unstable, 0);
    check({name, " req_drop"}, drop_bad, 0);
    check({name, " pix_count"}, o_pix_count, exp_nw);
    check({name, " idle_after"}, o_busy, 0);
    if (px[0] < 800 && py[0] < 600) check({name, " first_req_cycle"}, first_wr, 4);
    i_abort = 1'b0;
    wr_bus.wr_ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int n;
    wr_bus.wr_ack = 1'b0;

    repeat (3) @(negedge clk);
    check("reset busy", o_busy, 0);
    check("reset wr_req", wr_bus.wr_req, 0);
    check("reset pix_count", o_pix_count, 0);
    check("reset wr_data", wr_bus.wr_data, 0);
    check("reset wr_addr", wr_bus.wr_addr, 0);
    rst = 1'b0;
    @(negedge clk);

    px[0] = 5; py[0] = 2; pd[0] = 1;
    run_rect("single", 1, 0, -1, 0, 16'h1234);

    px[0] = 0;   py[0] = 0;   pd[0] = 0;
    px[1] = 799; py[1] = 599; pd[1] = 0;
    px[2] = 1;   py[2] = 0;   pd[2] = 1;
    run_rect("three", 3, 3, -1, 0, 16'hA5C3);

    px[0] = 801; py[0] = 601; pd[0] = 0;
    px[1] = 800; py[1] = 10;  pd[1] = 0;
    px[2] = 3;   py[2] = 3;   pd[2] = 1;
    run_rect("clip", 3, 1, -1, 0, 16'h0F0F);

    px[0] = 7; py[0] = 7; pd[0] = 0;
    px[1] = 8; py[1] = 8; pd[1] = 1;
    run_rect("abort", 2, 5, 0, 0, 16'h7777);

    px[0] = 10; py[0] = 10; pd[0] = 0;
    px[1] = 10; py[1] = 10; pd[1] = 0;
    px[2] = 11; py[2] = 11; pd[2] = 1;
    run_rect("stall", 3, 0, -1, 0, 16'h00FF);

    px[0] = 20; py[0] = 30; pd[0] = 0;
    px[1] = 21; py[1] = 30; pd[1] = 0;
    px[2] = 22; py[2] = 30; pd[2] = 1;
    run_rect("busy_req", 3, 3, -1, 1, 16'h5A5A);

    // Reset in the middle of a write
    px[0] = 5; py[0] = 5; pd[0] = 1;
    i_x_pos = 16'd5; i_y_pos = 16'd5; i_all_done = 1'b1;
    @(negedge clk);
    i_color = 16'hBEEF;
    i_draw_req = 1'b1;
    @(negedge clk);
    i_draw_req = 1'b0;
    for (int k = 0; k < 20 && !wr_bus.wr_req; k++) @(negedge clk);
    check("rst_mid req_before", wr_bus.wr_req, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid wr_req", wr_bus.wr_req, 0);
    check("rst_mid busy", o_busy, 0);
    check("rst_mid wr_data", wr_bus.wr_data, 0);
    check("rst_mid wr_addr", wr_bus.wr_addr, 0);
    check("rst_mid pulses", {o_start_to_output, o_renew, o_frame_done, o_error}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid still_idle", o_busy, 0);

    for (int t = 0; t < 20; t++) begin
      n = int'($urandom_range(1, 6));
      for (int i = 0; i < n; i++) begin
        px[i] = int'($urandom_range(0, 899));
        py[i] = int'($urandom_range(0, 699));
        pd[i] = (i == n - 1);
      end
      run_rect("random", n, int'($urandom_range(0, 3)), -1, 0, 16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
